if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC and issues in-order read requests to instruction memory over a valid/ready handshake.
- Pairs each returned instruction with its PC in a small circular buffer and presents them in order to decode.
- Drives im_stall back to the PC so the PC only advances when a fetch for the current PC has been accepted; a flush on redirect discards in-flight and buffered fetches.

Parameters:
- DEPTH, 4: buffer entries; also the cap on total in-flight plus buffered fetches; power of two, at least 2.
- RESET_PC, 32'h0: value reported on dec_pc while the buffer is empty after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pc_in  in  32  current PC from the program counter
- fetch_en  in  1  fetching permitted
- flush  in  1  redirect (branch/CSR): drop all buffered and outstanding fetches
- im_req_valid  out  1  instruction memory request valid
- im_req_ready  in  1  instruction memory accepts the request
- im_req_addr  out  32  request address, equal to pc_in
- im_resp_valid  in  1  instruction memory response; responses return in order, at least 1 cycle after acceptance
- im_resp_data  in  32  returned instruction
- im_stall  out  1  to PC: hold, because the current PC's fetch was not accepted this cycle
- dec_valid  out  1  head entry holds a returned instruction
- dec_ready  in  1  decode consumes the head entry
- dec_inst  out  32  head instruction
- dec_pc  out  32  head PC

Behaviour:
- Reset: all entries invalid; head, tail, fill and response pointers = 0; count = 0; drop_cnt = 0.
  - Output values under reset: im_req_valid = 0, im_stall = 1, dec_valid = 0, dec_inst = 0, dec_pc = RESET_PC.
- Entry format: {pc[31:0], inst[31:0], done}. Pointers: tail (allocate), fill (next entry awaiting response), head (dequeue). All wrap modulo DEPTH.
- Counters: count (allocated entries) and drop_cnt (responses still owed to flushed requests) are clog2(DEPTH+1) bits wide and use registered values only.
- Request issue:
  - im_req_valid = fetch_en & ~flush & (count + drop_cnt < DEPTH).
  - im_req_addr = pc_in, combinational.
  - On im_req_valid & im_req_ready: allocate entry[tail] with pc = pc_in and done = 0; tail++, count++.
- im_stall = ~(im_req_valid & im_req_ready), combinational. The PC advances only in cycles where the fetch is accepted.
- Response handling:
  - On im_resp_valid with drop_cnt > 0 and no flush: discard the response; drop_cnt--.
  - Otherwise: write inst into entry[fill], set done = 1, fill++.
  - A response never targets an entry allocated in the same cycle.
- Dequeue:
  - dec_valid = entry[head].done; dec_inst and dec_pc come from entry[head], combinational.
  - On dec_valid & dec_ready: clear done, head++, count--.
  - Zero-cycle bypass of a response to decode is not allowed: an instruction is visible to decode 1 cycle after im_resp_valid.
- Simultaneous events:
  - Allocate and dequeue in the same cycle: count unchanged.
  - When count + drop_cnt == DEPTH, no request is issued even if a dequeue happens in that cycle (no same-cycle bypass).
- Flush has priority over every other action in its cycle:
  - All entries invalidated; head = tail = fill = 0; count = 0.
  - drop_cnt = drop_cnt + (entries allocated but not done) − (im_resp_valid ? 1 : 0). The response arriving in the flush cycle is consumed and discarded.
  - No request in the flush cycle; dec_valid is still driven from pre-flush state, but no pop occurs.
- reset asserted mid-operation: immediate return to reset state. Memory responses for pre-reset requests are the memory side's responsibility.
- Error conditions, to be flagged by assertions in simulation:
  - im_resp_valid with nothing outstanding.
  - count > DEPTH.

Decomposition:
- Shared package if_pkg:
  - XLEN = 32.
  - The fetch-entry struct typedef {pc, inst, done}.
  - The RESET_PC default constant.
- One natural sub-module: if_entry_ring, the DEPTH-entry storage with tail/fill/head pointers and the count. if_fetch_buffer holds the handshake, stall and drop_cnt logic.

Test Plan:
- Reset, then fetch_en=1, im_req_ready=1, 1-cycle memory, dec_ready=1: dec_pc sequence 0x0, 0x4, 0x8; im_stall = 0 every cycle after the first.
- dec_ready=0, memory always ready: exactly 4 requests are accepted, then im_req_valid=0 and im_stall=1. Raise dec_ready: entries drain in order.
- im_req_ready low for 3 cycles with pc_in=0x100: im_stall=1 for those cycles; the single accepted request has im_req_addr=0x100.
- 3-cycle memory latency with 2 requests outstanding, flush in the same cycle as one response: both responses discarded (drop_cnt goes to 1, then 0); the next fetch at pc_in=0x8000 reaches decode with dec_pc=0x8000.
- Allocate and pop in the same cycle at count=2: count stays 2; dec_inst matches the memory image word order.
- Assert reset while 2 entries are buffered: dec_valid=0, im_req_valid=0 and dec_pc=RESET_PC in the same cycle.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            done;
  } fetch_entry_t;

endpackage

// File: rtl/if_entry_ring.sv
// Circular store of fetch entries: tail allocates, fill receives responses in order, head dequeues.
module if_entry_ring
  import if_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_inst_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [CW-1:0]   count_o,
  output logic [CW-1:0]   pend_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t ent_q [DEPTH];
  fetch_entry_t ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    pend_d  = pend_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].done = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      pend_d  = '0;
    end else begin
      if (alloc_i) begin
        ent_d[tail_q].pc   = alloc_pc_i;
        ent_d[tail_q].done = 1'b0;
        tail_d             = tail_q + PW'(1);
      end
      if (fill_i) begin
        ent_d[fill_q].inst = fill_inst_i;
        ent_d[fill_q].done = 1'b1;
        fill_d             = fill_q + PW'(1);
      end
      if (pop_i) begin
        ent_d[head_q].done = 1'b0;
        head_d             = head_q + PW'(1);
      end
      count_d = count_q + CW'(alloc_i) - CW'(pop_i);
      // pend tracks entries allocated but still waiting for their response
      pend_d  = pend_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{pc: RESET_PC, inst: '0, done: 1'b0};
      end
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  assign head_o  = ent_q[head_q];
  assign count_o = count_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch stage: issues in-order memory requests for pc_in, stalls the PC until accepted,
// and presents returned instructions with their PCs to decode; flush drops in-flight work.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            fetch_en,
  input  logic            flush,
  output logic            im_req_valid,
  input  logic            im_req_ready,
  output logic [XLEN-1:0] im_req_addr,
  input  logic            im_resp_valid,
  input  logic [XLEN-1:0] im_resp_data,
  output logic            im_stall,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;

  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic [CW-1:0] pend;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW1-1:0] occupancy;
  logic          has_room;
  logic          accept;
  logic          dropping;
  logic          fill;
  logic          pop;

  // Outstanding flushed responses still occupy slots, so they count against capacity.
  assign occupancy    = {1'b0, count} + {1'b0, drop_cnt_q};
  assign has_room     = occupancy < CW1'(DEPTH);
  assign im_req_valid = ~reset & fetch_en & ~flush & has_room;
  assign im_req_addr  = pc_in;
  assign accept       = im_req_valid & im_req_ready;
  assign im_stall     = ~accept;

  assign dropping = im_resp_valid & (drop_cnt_q != '0);
  assign fill     = im_resp_valid & ~dropping & ~flush;

  assign dec_valid = head.done;
  assign dec_inst  = head.inst;
  assign dec_pc    = head.pc;
  assign pop       = dec_valid & dec_ready & ~flush;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = drop_cnt_q + pend - CW'(im_resp_valid);
    end else if (dropping) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  if_entry_ring #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .alloc_i     (accept),
    .alloc_pc_i  (pc_in),
    .fill_i      (fill),
    .fill_inst_i (im_resp_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .pend_o      (pend)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(im_resp_valid && (drop_cnt_q == '0) && (pend == '0)))
        else $error("if_fetch_buffer: memory response with nothing outstanding");
      assert (count <= CW'(DEPTH))
        else $error("if_fetch_buffer: entry count exceeds DEPTH");
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed, table-driven bench for if_fetch_buffer with an in-order latency memory model.
module tb_if_fetch_buffer;
  import if_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = '0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic        im_req_valid;
  logic        im_req_ready = 1'b0;
  logic [31:0] im_req_addr;
  logic        im_resp_valid = 1'b0;
  logic [31:0] im_resp_data = '0;
  logic        im_stall;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .fetch_en      (fetch_en),
    .flush         (flush),
    .im_req_valid  (im_req_valid),
    .im_req_ready  (im_req_ready),
    .im_req_addr   (im_req_addr),
    .im_resp_valid (im_resp_valid),
    .im_resp_data  (im_resp_data),
    .im_stall      (im_stall),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          rst;
    bit          fen;
    bit          rdy;
    bit          drdy;
    logic [31:0] pc;
    bit          e_vld;
    bit          e_stall;
    bit          e_dv;
    logic [31:0] e_dpc;
  } vec_t;

  mreq_t mq[$];
  vec_t  tbl[$];
  int    cyc = 0;
  int    lat = 1;
  int    n_tests = 0;
  int    n_fail = 0;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h0001_0001) ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic v(input bit rst, input bit fen, input bit rdy, input bit drdy, input logic [31:0] pc,
                   input bit e_vld, input bit e_stall, input bit e_dv, input logic [31:0] e_dpc);
    vec_t r;
    r = '{rst: rst, fen: fen, rdy: rdy, drdy: drdy, pc: pc,
          e_vld: e_vld, e_stall: e_stall, e_dv: e_dv, e_dpc: e_dpc};
    tbl.push_back(r);
  endtask

  // Present this cycle's memory response, then let combinational outputs settle.
  task automatic settle();
    mreq_t r;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      im_resp_valid = 1'b1;
      im_resp_data  = img(r.addr);
    end else begin
      im_resp_valid = 1'b0;
      im_resp_data  = '0;
    end
    #1;
  endtask

  task automatic finish_cycle();
    mreq_t r;
    if (im_req_valid && im_req_ready) begin
      r.addr = pc_in;
      r.due  = cyc + lat;
      mq.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_en = 1'b0; flush = 1'b0; im_req_ready = 1'b0; dec_ready = 1'b0;
    im_resp_valid = 1'b0; im_resp_data = '0; pc_in = '0;
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic drive(input bit fen, input bit rdy, input bit drdy, input logic [31:0] pc);
    fetch_en = fen; im_req_ready = rdy; dec_ready = drdy; pc_in = pc; flush = 1'b0;
  endtask

  initial begin
    // basic streaming, 1-cycle memory
    v(1,1,1,1,32'h00, 1,0,0,0);
    v(0,1,1,1,32'h04, 1,0,0,0);
    v(0,1,1,1,32'h08, 1,0,1,32'h0);
    v(0,1,1,1,32'h0C, 1,0,1,32'h4);
    v(0,1,1,1,32'h10, 1,0,1,32'h8);
    v(0,1,1,1,32'h14, 1,0,1,32'hC);
    // decode blocked: buffer fills to DEPTH, then drains in order
    v(1,1,1,0,32'h00, 1,0,0,0);
    v(0,1,1,0,32'h04, 1,0,0,0);
    v(0,1,1,0,32'h08, 1,0,1,32'h0);
    v(0,1,1,0,32'h0C, 1,0,1,32'h0);
    v(0,1,1,0,32'h10, 0,1,1,32'h0);
    v(0,1,1,0,32'h10, 0,1,1,32'h0);
    v(0,1,1,1,32'h10, 0,1,1,32'h0);
    v(0,1,1,1,32'h10, 1,0,1,32'h4);
    v(0,1,1,1,32'h14, 1,0,1,32'h8);
    v(0,1,1,1,32'h18, 1,0,1,32'hC);
    v(0,1,1,1,32'h1C, 1,0,1,32'h10);
    v(0,1,1,1,32'h20, 1,0,1,32'h14);
    // memory not ready for 3 cycles
    v(1,1,0,1,32'h100, 1,1,0,0);
    v(0,1,0,1,32'h100, 1,1,0,0);
    v(0,1,0,1,32'h100, 1,1,0,0);
    v(0,1,1,1,32'h100, 1,0,0,0);
    v(0,1,0,1,32'h104, 1,1,0,0);
    v(0,1,0,1,32'h104, 1,1,1,32'h100);
    v(0,1,0,1,32'h104, 1,1,0,0);

    // state while reset is held
    reset = 1'b1; fetch_en = 1'b1; im_req_ready = 1'b1; dec_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst.req_valid", 32'(im_req_valid), 32'd0);
    chk("rst.stall",     32'(im_stall),     32'd1);
    chk("rst.dec_valid", 32'(dec_valid),    32'd0);
    chk("rst.dec_inst",  dec_inst,          32'd0);
    chk("rst.dec_pc",    dec_pc,            RPC);

    lat = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].fen, tbl[i].rdy, tbl[i].drdy, tbl[i].pc);
      settle();
      chk($sformatf("v%0d.req_valid", i), 32'(im_req_valid), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d.stall", i),     32'(im_stall),     32'(tbl[i].e_stall));
      chk($sformatf("v%0d.dec_valid", i), 32'(dec_valid),    32'(tbl[i].e_dv));
      if (tbl[i].e_vld) chk($sformatf("v%0d.req_addr", i), im_req_addr, tbl[i].pc);
      if (tbl[i].e_dv) begin
        chk($sformatf("v%0d.dec_pc", i),   dec_pc,   tbl[i].e_dpc);
        chk($sformatf("v%0d.dec_inst", i), dec_inst, img(tbl[i].e_dpc));
      end
      finish_cycle();
    end

    // flush with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    drive(1,1,1,32'h0); settle(); finish_cycle();
    drive(1,1,1,32'h4); settle(); finish_cycle();
    drive(0,1,1,32'h8); settle(); chk("fl.c2.dec_valid", 32'(dec_valid), 32'd0); finish_cycle();
    drive(1,1,1,32'h8000); flush = 1'b1; settle();
    chk("fl.c3.resp_seen", 32'(im_resp_valid), 32'd1);
    chk("fl.c3.req_valid", 32'(im_req_valid), 32'd0);
    chk("fl.c3.stall",     32'(im_stall),     32'd1);
    chk("fl.c3.dec_valid", 32'(dec_valid),    32'd0);
    finish_cycle();
    chk("fl.drop_after_flush", 32'(dut.drop_cnt_q), 32'd1);
    drive(0,1,1,32'h8000); settle();
    chk("fl.c4.resp_seen", 32'(im_resp_valid), 32'd1);
    chk("fl.c4.dec_valid", 32'(dec_valid), 32'd0);
    finish_cycle();
    chk("fl.drop_after_discard", 32'(dut.drop_cnt_q), 32'd0);
    drive(1,1,1,32'h8000); settle(); chk("fl.c5.req_valid", 32'(im_req_valid), 32'd1); finish_cycle();
    drive(0,1,1,32'h8004);
    for (int k = 6; k <= 8; k++) begin
      settle(); chk($sformatf("fl.c%0d.dec_valid", k), 32'(dec_valid), 32'd0); finish_cycle();
    end
    settle();
    chk("fl.c9.dec_valid", 32'(dec_valid), 32'd1);
    chk("fl.c9.dec_pc",    dec_pc,   32'h8000);
    chk("fl.c9.dec_inst",  dec_inst, img(32'h8000));
    finish_cycle();
    settle(); chk("fl.c10.dec_valid", 32'(dec_valid), 32'd0); finish_cycle();

    // allocate and pop in the same cycle at count 2
    do_reset();
    lat = 1;
    drive(1,1,0,32'h0); settle(); finish_cycle();
    drive(1,1,0,32'h4); settle(); finish_cycle();
    drive(0,1,0,32'h8); settle(); finish_cycle();
    drive(1,1,1,32'h8); settle();
    chk("ap.req_valid", 32'(im_req_valid), 32'd1);
    chk("ap.dec_pc",    dec_pc,   32'h0);
    chk("ap.dec_inst",  dec_inst, img(32'h0));
    finish_cycle();
    chk("ap.count", 32'(dut.u_ring.count_q), 32'd2);
    drive(0,1,1,32'hC); settle();
    chk("ap.c4.dec_pc",   dec_pc,   32'h4);
    chk("ap.c4.dec_inst", dec_inst, img(32'h4));
    finish_cycle();
    settle();
    chk("ap.c5.dec_valid", 32'(dec_valid), 32'd1);
    chk("ap.c5.dec_pc",    dec_pc,   32'h8);
    chk("ap.c5.dec_inst",  dec_inst, img(32'h8));
    finish_cycle();
    settle(); chk("ap.c6.dec_valid", 32'(dec_valid), 32'd0); finish_cycle();

    // reset mid-operation with two buffered entries
    do_reset();
    lat = 1;
    drive(1,1,0,32'h0); settle(); finish_cycle();
    drive(1,1,0,32'h4); settle(); finish_cycle();
    drive(0,1,0,32'h8); settle(); finish_cycle();
    settle();
    chk("mr.pre.dec_valid", 32'(dec_valid), 32'd1);
    fetch_en = 1'b1; im_req_ready = 1'b1; reset = 1'b1;
    #1;
    chk("mr.req_valid", 32'(im_req_valid), 32'd0);
    chk("mr.stall",     32'(im_stall),     32'd1);
    chk("mr.dec_valid", 32'(dec_valid),    32'd0);
    chk("mr.dec_pc",    dec_pc,            RPC);
    chk("mr.dec_inst",  dec_inst,          32'd0);
    mq.delete();
    im_resp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    drive(1,1,1,32'h40); settle(); finish_cycle();
    drive(0,1,1,32'h44); settle(); finish_cycle();
    settle();
    chk("mr.post.dec_valid", 32'(dec_valid), 32'd1);
    chk("mr.post.dec_pc",    dec_pc, 32'h40);
    finish_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
